// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side controllers of the async FIFO.
// Functions work on zero-extended MAX_PW-bit values, so one definition serves every width.
package fifo_pkg;

  localparam int MAX_PW = 17;
  typedef logic [MAX_PW-1:0] ptr_t;

  localparam ptr_t PTR_RST  = '0;
  localparam logic FLAG_RST = 1'b0;

  function automatic int depth_of(input int ptr_width);
    return 1 << ptr_width;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero bits above the real MSB leave the prefix XOR unchanged.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Write pointer is one full lap ahead: top two Gray bits inverted, rest equal.
  function automatic logic full_match(input ptr_t gw, input ptr_t gr, input int w);
    ptr_t m;
    m = '0;
    m[w-1] = 1'b1;
    m[w-2] = 1'b1;
    return gw == (gr ^ m);
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-bit flop synchroniser for Gray pointers; STAGES cycles of latency, no handshake.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/wptr_ctrl.sv
// Write-side pointer controller: pointers, full/almost-full, free count, sticky overflow; state updates one edge after w_fire.
// Writes while full are dropped (w_fire=0); WPTR_INT_SYNC_EN adds an internal SYNC_STAGES read-pointer synchroniser.
module wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr_sync,
  input  logic [PTR_WIDTH:0] af_thresh,
  input  logic               clr_ovf,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic               w_fire,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] wfree,
  output logic               overflow
);

  localparam int W = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] DEPTH_V = W'(depth_of(PTR_WIDTH));

  if (PTR_WIDTH < 2 || PTR_WIDTH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
    $error("wptr_ctrl: parameter out of range");
  end

  logic [PTR_WIDTH:0] g_rptr_s;
  logic [PTR_WIDTH:0] b_rptr_s;
  logic [PTR_WIDTH:0] b_wptr_next;
  logic [PTR_WIDTH:0] g_wptr_next;
  logic [PTR_WIDTH:0] wfree_next;
  logic               full_next;

`ifdef WPTR_INT_SYNC_EN
  ptr_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (g_rptr_sync),
    .q   (g_rptr_s)
  );
`else
  assign g_rptr_s = g_rptr_sync;
`endif

  assign w_fire      = w_en & ~full;
  assign waddr       = b_wptr[PTR_WIDTH-1:0];
  assign b_wptr_next = b_wptr + W'(w_fire);
  assign g_wptr_next = W'(bin2gray(ptr_t'(b_wptr_next)));
  assign b_rptr_s    = W'(gray2bin(ptr_t'(g_rptr_s)));
  assign full_next   = full_match(ptr_t'(g_wptr_next), ptr_t'(g_rptr_s), W);
  // A stale read pointer only under-reports free space, never over-reports it.
  assign wfree_next  = DEPTH_V - (b_wptr_next - b_rptr_s);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      b_wptr      <= PTR_RST[PTR_WIDTH:0];
      g_wptr      <= PTR_RST[PTR_WIDTH:0];
      full        <= FLAG_RST;
      almost_full <= FLAG_RST;
      wfree       <= DEPTH_V;
      overflow    <= FLAG_RST;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= full_next;
      almost_full <= (wfree_next <= af_thresh);
      wfree       <= wfree_next;
      if (w_en & full) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_ctrl.sv
// Scoreboard bench for wptr_ctrl: occupancy-count reference model, randomized writes/reads/thresholds.
module tb_wptr_ctrl;

  localparam int PW    = 3;
  localparam int W     = PW + 1;
  localparam int DEPTH = 8;
`ifdef WPTR_INT_SYNC_EN
  localparam int SV = 2;
`else
  localparam int SV = 0;
`endif

  logic         wclk;
  logic         wrst;
  logic         w_en;
  logic [W-1:0] g_rptr_sync;
  logic [W-1:0] af_thresh;
  logic         clr_ovf;
  logic [W-1:0] b_wptr;
  logic [W-1:0] g_wptr;
  logic [PW-1:0] waddr;
  logic         w_fire;
  logic         full;
  logic         almost_full;
  logic [W-1:0] wfree;
  logic         overflow;

  wptr_ctrl #(.PTR_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .af_thresh   (af_thresh),
    .clr_ovf     (clr_ovf),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .waddr       (waddr),
    .w_fire      (w_fire),
    .full        (full),
    .almost_full (almost_full),
    .wfree       (wfree),
    .overflow    (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    int b;
    int g;
    int full;
    int af;
    int ovf;
    int free;
  } exp_t;

  exp_t eq[$];
  int   fq[$];
  int   rq[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: total accepted writes and reads since reset, plus registered flags.
  int wcnt, rcount, m_full, m_free, m_af, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int x);
    int b;
    b = x % (2 * DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wcnt = 0; rcount = 0;
    m_full = 0; m_free = DEPTH; m_af = 0; m_ovf = 0;
    rq.delete(); eq.delete(); fq.delete();
  endtask

  task automatic step(input int we, input int rd, input int th, input int clr);
    int   rv, occ, fire;
    exp_t e;
    @(negedge wclk);
    wrst = 1'b0;
    if (rd != 0 && rcount < wcnt) rcount++;
    w_en        = (we != 0);
    clr_ovf     = (clr != 0);
    af_thresh   = W'(th);
    g_rptr_sync = W'(gray(rcount));
    rq.push_back(rcount);
    rv = (rq.size() > SV) ? rq[rq.size() - 1 - SV] : 0;
    if (rq.size() > 8) void'(rq.pop_front());
    fire = (we != 0 && m_full == 0) ? 1 : 0;
    fq.push_back(fire);
    if (we != 0 && m_full != 0) m_ovf = 1;
    else if (clr != 0) m_ovf = 0;
    wcnt += fire;
    occ    = wcnt - rv;
    m_full = (occ == DEPTH) ? 1 : 0;
    m_free = DEPTH - occ;
    m_af   = (m_free <= th) ? 1 : 0;
    e.b = wcnt % (2 * DEPTH);
    e.g = gray(wcnt);
    e.full = m_full;
    e.af = m_af;
    e.ovf = m_ovf;
    e.free = m_free;
    eq.push_back(e);
  endtask

  task automatic async_reset();
    #2;
    wrst = 1'b1;
    eq.delete();
    fq.delete();
    #1;
    chk("rst_b_wptr", int'(b_wptr), 0);
    chk("rst_g_wptr", int'(g_wptr), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_wfree", int'(wfree), DEPTH);
    chk("rst_almost_full", int'(almost_full), 0);
    model_reset();
    repeat (2) @(posedge wclk);
  endtask

  initial begin : state_monitor
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("b_wptr", int'(b_wptr), e.b);
        chk("g_wptr", int'(g_wptr), e.g);
        chk("waddr", int'(waddr), e.b % DEPTH);
        chk("full", int'(full), e.full);
        chk("almost_full", int'(almost_full), e.af);
        chk("wfree", int'(wfree), e.free);
        chk("overflow", int'(overflow), e.ovf);
      end
    end
  end

  initial begin : fire_monitor
    int f;
    forever begin
      @(negedge wclk);
      #1;
      if (fq.size() > 0) begin
        f = fq.pop_front();
        chk("w_fire", int'(w_fire), f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    wrst = 1'b1; w_en = 1'b0; clr_ovf = 1'b0; af_thresh = '0; g_rptr_sync = '0;
    model_reset();
    #12;

    repeat (10) step(1, 0, 2, 0);
    @(posedge wclk); #1;
    chk("fill_b_wptr", int'(b_wptr), 8);
    chk("fill_g_wptr", int'(g_wptr), 12);
    chk("fill_full", int'(full), 1);
    chk("fill_wfree", int'(wfree), 0);
    chk("fill_almost_full", int'(almost_full), 1);
    chk("fill_overflow", int'(overflow), 1);

    step(1, 0, 2, 1);
    @(posedge wclk); #1;
    chk("ovf_set_wins", int'(overflow), 1);
    chk("ovf_ptr_hold", int'(b_wptr), 8);
    step(0, 0, 2, 1);
    @(posedge wclk); #1;
    chk("ovf_clear", int'(overflow), 0);

    step(0, 1, 2, 0);
    repeat (SV) step(0, 0, 2, 0);
    @(posedge wclk); #1;
    chk("release_full", int'(full), 0);
    chk("release_wfree", int'(wfree), 1);

    step(0, 0, 8, 0);
    async_reset();
    step(0, 0, 8, 0);
    @(posedge wclk); #1;
    chk("af_thresh8_first_edge", int'(almost_full), 1);

    repeat (60) step(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0, 0, 0);

    repeat (40) step(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 7) == 0) ? 1 : 0);
    async_reset();
    step(1, 0, 3, 0);
    @(posedge wclk); #1;
    chk("rst_first_b_wptr", int'(b_wptr), 1);
    chk("rst_first_g_wptr", int'(g_wptr), 1);

    repeat (200) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0) ? 1 : 0);

    repeat (2) @(posedge wclk);
    #2;
    chk("queue_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_ctrl.md
Name: wptr_ctrl

Overview:
- Next-generation write-side pointer controller for the async FIFO, running in the write clock domain.
- Produces the binary and Gray write pointers, RAM write address and registered full flag.
- Adds to the previous generation:
  - free-space count
  - programmable almost-full watermark
  - sticky overflow error with clear
  - optional internal read-pointer synchroniser
- Feeds the FIFO memory and the read-domain synchroniser. Consumes the Gray read pointer from the read domain.

Parameters:
- PTR_WIDTH, 3, address bits; DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits. Legal range 2..16.
- SYNC_STAGES, 2, flop stages of the internal g_rptr synchroniser. Used only with WPTR_INT_SYNC_EN; legal range 2..4.

Ports:
- wclk  in  1  write clock
- wrst  in  1  asynchronous active-high reset
- w_en  in  1  write request; accepted only when full=0
- g_rptr_sync  in  PTR_WIDTH+1  Gray read pointer. Already synchronised to wclk, or raw when WPTR_INT_SYNC_EN is defined.
- af_thresh  in  PTR_WIDTH+1  almost-full threshold in free entries, 0..DEPTH
- clr_ovf  in  1  clears the overflow flag
- b_wptr  out  PTR_WIDTH+1  binary write pointer
- g_wptr  out  PTR_WIDTH+1  Gray write pointer
- waddr  out  PTR_WIDTH  RAM write address, equal to b_wptr[PTR_WIDTH-1:0]
- w_fire  out  1  combinational: w_en & ~full, the RAM write strobe
- full  out  1  registered full flag
- almost_full  out  1  registered watermark flag
- wfree  out  PTR_WIDTH+1  registered free entries, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (async, wrst=1): b_wptr=0, g_wptr=0, full=0, overflow=0, wfree=DEPTH.
  - almost_full is reset to 0, then is (DEPTH <= af_thresh) from the first clock edge after reset.
  - Synchroniser flops reset to 0.
- Reset asserted mid-operation clears all state immediately, with no clock needed. Release is synchronous to the wclk edge (external reset-release synchroniser).
- Pointer advance:
  - b_wptr_next = b_wptr + w_fire, modulo 2**(PTR_WIDTH+1). Wraps freely from all-ones to 0.
  - g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1).
  - Both are registered every wclk edge.
- Read pointer in wclk domain: b_rptr_s = Gray-to-binary of the synchronised g_rptr (XOR prefix from MSB).
- Full: full <= (g_wptr_next == {~g_rptr_s[MSB:MSB-1], g_rptr_s[MSB-2:0]}).
- Write latency:
  - w_fire in cycle N updates b_wptr, g_wptr, full and wfree at edge N+1.
  - The data write to RAM happens in cycle N at the old waddr.
- wfree <= DEPTH - (b_wptr_next - b_rptr_s), computed in PTR_WIDTH+1 modulo arithmetic. wfree == 0 if and only if full.
- almost_full <= (wfree_next <= af_thresh):
  - af_thresh = 0 makes almost_full equal to full.
  - af_thresh >= DEPTH forces almost_full to 1.
  - af_thresh may change at any time; the change takes effect at the next edge.
- Overflow:
  - Set when w_en & full at the clock edge.
  - Cleared by clr_ovf.
  - Set and clear in the same cycle: set wins.
  - overflow does not block writes.
- Writes while full are dropped: pointers do not move, RAM is not written.
- Simultaneous read progress and write in the same cycle: wfree reflects the new write and the currently visible b_rptr_s. Free space is released conservatively, never over-reported.
- Stale read pointer only delays space release; full is never deasserted early.

Optional Feature:
- Macro: WPTR_INT_SYNC_EN.
- Defined:
  - g_rptr_sync is treated as asynchronous.
  - It passes through SYNC_STAGES flops on wclk, reset to 0, before use.
  - Adds SYNC_STAGES cycles to read-pointer visibility.
- Undefined:
  - g_rptr_sync is used directly as already synchronised.
  - No extra flops.

Decomposition:
- Shared package fifo_pkg holds:
  - gray-to-binary and binary-to-gray functions, parametrised by width
  - the full-compare function
  - the DEPTH derivation
  - reset value constants
- One sub-module, ptr_sync (SYNC_STAGES-deep multi-bit flop synchroniser with async active-high reset). Instantiated only under WPTR_INT_SYNC_EN and reused by the read-side controller.

Test Plan:
- Fill: PTR_WIDTH=3, g_rptr_sync=0, af_thresh=2, w_en=1 for 10 cycles:
  - wfree steps 8→0
  - almost_full rises when wfree=2
  - full=1 after the 8th accepted write
  - b_wptr=8, g_wptr=4'b1100
- Overflow: with full=1, hold w_en for 2 more cycles:
  - pointers stay at 8
  - w_fire=0
  - overflow=1
  - clr_ovf with w_en=1 in the same cycle leaves overflow=1; clr_ovf alone clears it.
- Space release: full FIFO, step g_rptr_sync to Gray(1)=4'b0001:
  - full=0 and wfree=1 one edge later; internal-sync build: SYNC_STAGES+1 edges later.
- Wrap: drive read pointer behind, 20 writes with reads interleaved:
  - b_wptr wraps 15→0
  - g_wptr changes exactly 1 bit per accepted write
  - full matches the reference model every cycle
- Async reset: assert wrst mid-burst between clock edges:
  - all outputs at reset values immediately
  - first write after release gives b_wptr=1, g_wptr=4'b0001
- Threshold extremes:
  - af_thresh=0: almost_full tracks full
  - af_thresh=8: almost_full=1 from the first edge after reset
